// File: rtl/sipo_frame_receiver.sv
// rtl/sipo_frame_receiver.sv - MSB-first serial frame receiver with parity/stop checks
// and a one-word valid/ready holding buffer.
module sipo_frame_receiver #(
  parameter int WIDTH      = 4,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_en,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             par_err,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             perr_q, perr_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             par_err_q, par_err_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic             par_on;
  logic             odd_on;

  assign par_on = (PARITY_EN != 0);
  assign odd_on = (ODD_PARITY != 0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    data_d    = data_q;
    valid_d   = valid_q;
    par_err_d = par_err_q;

    if (s_en) begin
      case (state_q)
        IDLE: begin
          if (s_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shreg_d = {shreg_q[WIDTH-2:0], s_in};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = par_on ? PARITY : STOP;
          end
        end
        PARITY: begin
          perr_d  = s_in ^ (^shreg_q) ^ odd_on;
          state_d = STOP;
        end
        STOP: begin
          // A high stop bit ends the frame; it is never taken as the next start bit.
          state_d = IDLE;
          if (s_in) ferr_d = 1'b1;
          else      done_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (valid_q && o_ready) valid_d = 1'b0;

    // The completed word stays in shreg_q for the cycle after the stop bit,
    // since the IDLE state never shifts.
    if (done_q) begin
      if (!valid_q || o_ready) begin
        data_d    = shreg_q;
        par_err_d = par_on && perr_q;
        valid_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      done_q    <= done_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign par_err   = par_err_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// tb/tb_sipo_frame_receiver.sv - self-checking bench for sipo_frame_receiver
// (WIDTH=4, even parity).
module tb_sipo_frame_receiver;

  localparam int W   = 4;
  localparam bit ODD = 1'b0;

  logic         clk;
  logic         rst;
  logic         s_in;
  logic         s_en;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         o_ready;
  logic         par_err;
  logic         frame_err;
  logic         overrun;

  int chk_cnt;
  int pass_cnt;
  int fe_cnt;
  int ov_cnt;

  sipo_frame_receiver #(.WIDTH(W), .PARITY_EN(1), .ODD_PARITY(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_in     (s_in),
    .s_en     (s_en),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .par_err  (par_err),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters: each count is the number of cycles the flag was high.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
    end
  end

  function automatic logic good_par(input logic [W-1:0] w);
    return (^w) ^ ODD;
  endfunction

  task automatic send_bit(input logic b);
    s_in = b;
    s_en = 1'b1;
    @(posedge clk);
    #1;
    s_en = 1'b0;
  endtask

  task automatic idle_cycle();
    s_en = 1'b0;
    s_in = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic pbit, input logic stop, input bit gap);
    logic [W+2:0] bits;
    bits = {1'b1, w, pbit, stop};
    for (int i = W + 2; i >= 0; i--) begin
      if (gap) idle_cycle();
      send_bit(bits[i]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; o_ready = 1'b0; s_en = 1'b1; s_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", o_valid); else pass_cnt++;
    chk_cnt++; if (o_data !== '0) $display("FAIL reset_data got=%b exp=0000", o_data); else pass_cnt++;
    chk_cnt++; if ({par_err, frame_err, overrun} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {par_err, frame_err, overrun}); else pass_cnt++;
    s_en = 1'b0; s_in = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    o_ready = 1'b1;
    send_frame(4'b1010, good_par(4'b1010), 1'b0, 1'b0);
    chk_cnt++; if (o_valid !== 1'b0) $display("FAIL basic_latency got=%b exp=0", o_valid); else pass_cnt++;
    idle_cycle();
    chk_cnt++; if (o_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", o_valid); else pass_cnt++;
    chk_cnt++; if (o_data !== 4'b1010) $display("FAIL basic_data got=%b exp=1010", o_data); else pass_cnt++;
    chk_cnt++; if (par_err !== 1'b0) $display("FAIL basic_par got=%b exp=0", par_err); else pass_cnt++;
    idle_cycle();
    chk_cnt++; if (o_valid !== 1'b0) $display("FAIL basic_drain got=%b exp=0", o_valid); else pass_cnt++;
  endtask

  task automatic test_parity_err();
    o_ready = 1'b1;
    send_frame(4'b1010, ~good_par(4'b1010), 1'b0, 1'b0);
    idle_cycle();
    chk_cnt++; if (o_valid !== 1'b1) $display("FAIL perr_valid got=%b exp=1", o_valid); else pass_cnt++;
    chk_cnt++; if (o_data !== 4'b1010) $display("FAIL perr_data got=%b exp=1010", o_data); else pass_cnt++;
    chk_cnt++; if (par_err !== 1'b1) $display("FAIL perr_flag got=%b exp=1", par_err); else pass_cnt++;
    idle_cycle();
  endtask

  task automatic test_frame_err();
    o_ready = 1'b1;
    fe_cnt = 0; ov_cnt = 0;
    send_frame(4'b0110, 1'b1, 1'b1, 1'b0);
    idle_cycle();
    chk_cnt++; if (o_valid !== 1'b0) $display("FAIL ferr_valid1 got=%b exp=0", o_valid); else pass_cnt++;
    idle_cycle();
    chk_cnt++; if (o_valid !== 1'b0) $display("FAIL ferr_valid2 got=%b exp=0", o_valid); else pass_cnt++;
    chk_cnt++; if (fe_cnt !== 1) $display("FAIL ferr_pulse got=%0d exp=1", fe_cnt); else pass_cnt++;
    chk_cnt++; if (ov_cnt !== 0) $display("FAIL ferr_no_ovr got=%0d exp=0", ov_cnt); else pass_cnt++;
    send_frame(4'b0110, good_par(4'b0110), 1'b0, 1'b0);
    idle_cycle();
    chk_cnt++; if (o_data !== 4'b0110 || o_valid !== 1'b1) $display("FAIL ferr_next got=%b/%b exp=0110/1", o_data, o_valid); else pass_cnt++;
    idle_cycle();
  endtask

  task automatic test_overrun();
    o_ready = 1'b0;
    fe_cnt = 0; ov_cnt = 0;
    send_frame(4'b1010, good_par(4'b1010), 1'b0, 1'b0);
    send_frame(4'b0110, good_par(4'b0110), 1'b0, 1'b0);
    idle_cycle();
    idle_cycle();
    chk_cnt++; if (o_valid !== 1'b1) $display("FAIL ovr_valid got=%b exp=1", o_valid); else pass_cnt++;
    chk_cnt++; if (o_data !== 4'b1010) $display("FAIL ovr_hold got=%b exp=1010", o_data); else pass_cnt++;
    chk_cnt++; if (ov_cnt !== 1) $display("FAIL ovr_pulse got=%0d exp=1", ov_cnt); else pass_cnt++;
    o_ready = 1'b1;
    idle_cycle();
    chk_cnt++; if (o_valid !== 1'b0) $display("FAIL ovr_drain got=%b exp=0", o_valid); else pass_cnt++;
    chk_cnt++; if (o_data !== 4'b1010) $display("FAIL ovr_retain got=%b exp=1010", o_data); else pass_cnt++;
    o_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    o_ready = 1'b0;
    send_frame(4'b1010, good_par(4'b1010), 1'b0, 1'b0);
    idle_cycle();
    chk_cnt++; if (o_valid !== 1'b1 || o_data !== 4'b1010) $display("FAIL sim_pre got=%b/%b exp=1010/1", o_data, o_valid); else pass_cnt++;
    ov_cnt = 0;
    send_frame(4'b0011, good_par(4'b0011), 1'b0, 1'b0);
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    o_ready = 1'b0;
    chk_cnt++; if (o_valid !== 1'b1) $display("FAIL sim_valid got=%b exp=1", o_valid); else pass_cnt++;
    chk_cnt++; if (o_data !== 4'b0011) $display("FAIL sim_data got=%b exp=0011", o_data); else pass_cnt++;
    idle_cycle();
    idle_cycle();
    chk_cnt++; if (ov_cnt !== 0) $display("FAIL sim_no_ovr got=%0d exp=0", ov_cnt); else pass_cnt++;
    chk_cnt++; if (o_data !== 4'b0011 || o_valid !== 1'b1) $display("FAIL sim_hold got=%b/%b exp=0011/1", o_data, o_valid); else pass_cnt++;
    o_ready = 1'b1;
    idle_cycle();
    o_ready = 1'b0;
  endtask

  task automatic test_strobe_reset();
    o_ready = 1'b1;
    send_frame(4'b1101, good_par(4'b1101), 1'b0, 1'b1);
    idle_cycle();
    chk_cnt++; if (o_valid !== 1'b1 || o_data !== 4'b1101 || par_err !== 1'b0)
      $display("FAIL gap_decode got=%b/%b/%b exp=1101/1/0", o_data, o_valid, par_err); else pass_cnt++;
    idle_cycle();
    o_ready = 1'b0;
    send_frame(4'b0101, good_par(4'b0101), 1'b0, 1'b0);
    idle_cycle();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b0;
    #1;
    chk_cnt++; if (o_valid !== 1'b0) $display("FAIL rst_async_valid got=%b exp=0", o_valid); else pass_cnt++;
    chk_cnt++; if (o_data !== '0) $display("FAIL rst_async_data got=%b exp=0000", o_data); else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    o_ready = 1'b1;
    fe_cnt = 0; ov_cnt = 0;
    send_frame(4'b0111, good_par(4'b0111), 1'b0, 1'b0);
    idle_cycle();
    chk_cnt++; if (o_valid !== 1'b1 || o_data !== 4'b0111 || par_err !== 1'b0)
      $display("FAIL rst_next got=%b/%b/%b exp=0111/1/0", o_data, o_valid, par_err); else pass_cnt++;
    idle_cycle();
    chk_cnt++; if (fe_cnt !== 0 || ov_cnt !== 0) $display("FAIL rst_flags got=%0d/%0d exp=0/0", fe_cnt, ov_cnt); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    logic         bad_par;
    logic         bad_stop;
    bit           gap;
    o_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      w        = W'($urandom);
      bad_par  = ($urandom_range(0, 3) == 0);
      bad_stop = ($urandom_range(0, 4) == 0);
      gap      = 1'($urandom);
      fe_cnt = 0; ov_cnt = 0;
      send_frame(w, good_par(w) ^ bad_par, bad_stop, gap);
      idle_cycle();
      if (!bad_stop) begin
        chk_cnt++; if (o_valid !== 1'b1 || o_data !== w || par_err !== bad_par)
          $display("FAIL rand_word[%0d] got=%b/%b/%b exp=%b/1/%b", i, o_data, o_valid, par_err, w, bad_par); else pass_cnt++;
      end else begin
        chk_cnt++; if (o_valid !== 1'b0) $display("FAIL rand_ferr_valid[%0d] got=%b exp=0", i, o_valid); else pass_cnt++;
      end
      idle_cycle();
      chk_cnt++; if (fe_cnt !== int'(bad_stop) || ov_cnt !== 0)
        $display("FAIL rand_flags[%0d] got=%0d/%0d exp=%0d/0", i, fe_cnt, ov_cnt, bad_stop); else pass_cnt++;
    end
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0; fe_cnt = 0; ov_cnt = 0;
    s_in = 1'b0; s_en = 1'b0; o_ready = 1'b0; rst = 1'b0;
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_strobe_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
